// File: rtl/pred_pkg.sv
// Shared types and counter helpers for the local-history direction predictor.
package pred_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_RST_DEF = 2'b01;

    typedef enum logic {
        INIT,
        RUN
    } pred_state_e;

    function automatic ctr2_t sat_inc(input ctr2_t c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic ctr2_t sat_dec(input ctr2_t c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/pht_bank.sv
// One PHT bank of 2-bit counters: async lookup read, async update read, one sync write port.
module pht_bank
    import pred_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  ctr2_t            wdata_i,
    input  logic [IDX_W-1:0] lk_addr_i,
    output ctr2_t            lk_data_o,
    input  logic [IDX_W-1:0] up_addr_i,
    output ctr2_t            up_data_o
);

    ctr2_t mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign lk_data_o = mem[lk_addr_i];
    assign up_data_o = mem[up_addr_i];

endmodule

// File: rtl/local_dir_pred.sv
// Two-level local-history direction predictor: per-PC BHT feeding FETCH_W banked 2-bit PHTs,
// with a table-clear FSM and a two-stage forwarded update pipeline.
module local_dir_pred
    import pred_pkg::*;
#(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned BHT_NUM = 32,
    parameter int unsigned BHR_LEN = 6,
    parameter ctr2_t       CTR_RST = CTR_RST_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear_i,
    output logic               ready_o,
    input  logic [31:0]        fetch_pc_i,
    output logic [FETCH_W-1:0] taken_o,
    input  logic               upd_valid_i,
    input  logic [31:0]        upd_pc_i,
    input  logic               upd_taken_i
);

    localparam int unsigned BANK_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam int unsigned OFS    = 2 + $clog2(FETCH_W);
    localparam int unsigned BHT_W  = $clog2(BHT_NUM);
    localparam int unsigned PHT_N  = 2**BHR_LEN;
    localparam int unsigned CLR_N  = (BHT_NUM > PHT_N) ? BHT_NUM : PHT_N;
    localparam int unsigned CLR_W  = $clog2(CLR_N);

    typedef logic [BHR_LEN-1:0] bhr_t;
    typedef logic [BANK_W-1:0]  bank_t;
    typedef logic [BHT_W-1:0]   bidx_t;

    function automatic bank_t bank_of(input logic [31:0] pc);
        return BANK_W'((pc >> 2) & 32'(FETCH_W - 1));
    endfunction

    function automatic bidx_t bht_idx_of(input logic [31:0] pc);
        return BHT_W'(pc >> (OFS + BHR_LEN));
    endfunction

    function automatic bhr_t pc_hash(input logic [31:0] pc);
        return BHR_LEN'(pc >> OFS);
    endfunction

    pred_state_e      state_q, state_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic        u1_valid_q, u1_valid_d;
    logic [31:0] u1_pc_q, u1_pc_d;
    logic        u1_taken_q, u1_taken_d;

    logic  u2_valid_q, u2_valid_d;
    bidx_t u2_bht_idx_q, u2_bht_idx_d;
    bhr_t  u2_bhr_q, u2_bhr_d;
    bank_t u2_bank_q, u2_bank_d;
    bhr_t  u2_pht_idx_q, u2_pht_idx_d;
    ctr2_t u2_ctr_q, u2_ctr_d;

    bhr_t  bht_mem [BHT_NUM];
    logic  bht_we;
    bidx_t bht_waddr;
    bhr_t  bht_wdata;

    logic [FETCH_W-1:0] pht_we;
    bhr_t               pht_waddr;
    ctr2_t              pht_wdata;
    bhr_t               lk_addr [FETCH_W];
    ctr2_t              lk_data [FETCH_W];
    ctr2_t              up_data [FETCH_W];

    logic [31:0] slot_pc   [FETCH_W];
    bank_t       slot_bank [FETCH_W];
    bhr_t        slot_idx  [FETCH_W];

    bidx_t u1_bht_idx;
    bhr_t  u1_bhr;
    bank_t u1_bank;
    bhr_t  u1_pht_idx;
    ctr2_t u1_ctr;
    logic  u2_write;
    logic  in_init;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i, upd_pc_i, u1_pc_q};

    assign in_init = (state_q == INIT);
    assign ready_o = (state_q == RUN);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clear_i) begin
            state_d   = INIT;
            clr_cnt_d = '0;
        end else if (in_init) begin
            if (clr_cnt_q == CLR_W'(CLR_N - 1)) begin
                state_d = RUN;
            end else begin
                clr_cnt_d = clr_cnt_q + CLR_W'(1);
            end
        end
    end

    // U1 sees U2's pending write through forwarding, so a branch committed on consecutive
    // cycles indexes with its already-shifted history.
    always_comb begin
        u1_valid_d = upd_valid_i && (state_q == RUN) && !clear_i;
        u1_pc_d    = upd_pc_i;
        u1_taken_d = upd_taken_i;

        u1_bht_idx = bht_idx_of(u1_pc_q);
        u1_bhr     = (u2_valid_q && (u2_bht_idx_q == u1_bht_idx)) ? u2_bhr_q : bht_mem[u1_bht_idx];
        u1_bank    = bank_of(u1_pc_q);
        u1_pht_idx = u1_bhr ^ pc_hash(u1_pc_q);
        u1_ctr     = (u2_valid_q && (u2_bank_q == u1_bank) && (u2_pht_idx_q == u1_pht_idx))
                     ? u2_ctr_q : up_data[u1_bank];

        u2_valid_d   = u1_valid_q && !clear_i;
        u2_bht_idx_d = u1_bht_idx;
        u2_bhr_d     = bhr_t'({u1_bhr, u1_taken_q});
        u2_bank_d    = u1_bank;
        u2_pht_idx_d = u1_pht_idx;
        u2_ctr_d     = u1_taken_q ? sat_inc(u1_ctr) : sat_dec(u1_ctr);
    end

    assign u2_write = u2_valid_q && !clear_i;

    always_comb begin
        bht_we    = u2_write;
        bht_waddr = u2_bht_idx_q;
        bht_wdata = u2_bhr_q;
        pht_we    = '0;
        pht_waddr = u2_pht_idx_q;
        pht_wdata = u2_ctr_q;
        if (in_init) begin
            bht_we    = (32'(clr_cnt_q) < BHT_NUM);
            bht_waddr = BHT_W'(clr_cnt_q);
            bht_wdata = '0;
            pht_we    = (32'(clr_cnt_q) < PHT_N) ? '1 : '0;
            pht_waddr = BHR_LEN'(clr_cnt_q);
            pht_wdata = CTR_RST;
        end else begin
            for (int unsigned b = 0; b < FETCH_W; b++) begin
                pht_we[b] = u2_write && (32'(u2_bank_q) == b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bht_we) begin
            bht_mem[bht_waddr] <= bht_wdata;
        end
    end

    // Each slot lands in a distinct bank; route each slot's index to its bank's lookup port.
    always_comb begin
        for (int unsigned s = 0; s < FETCH_W; s++) begin
            slot_pc[s]   = {fetch_pc_i[31:2] + 30'(s), 2'b00};
            slot_bank[s] = bank_of(slot_pc[s]);
            slot_idx[s]  = bht_mem[bht_idx_of(slot_pc[s])] ^ pc_hash(slot_pc[s]);
        end
        for (int unsigned b = 0; b < FETCH_W; b++) begin
            lk_addr[b] = '0;
            for (int unsigned s = 0; s < FETCH_W; s++) begin
                if (32'(slot_bank[s]) == b) begin
                    lk_addr[b] = slot_idx[s];
                end
            end
        end
        taken_o = '0;
        if (state_q == RUN) begin
            for (int unsigned s = 0; s < FETCH_W; s++) begin
                taken_o[s] = lk_data[slot_bank[s]][1];
            end
        end
    end

    for (genvar b = 0; b < FETCH_W; b++) begin : g_bank
        pht_bank #(
            .IDX_W(BHR_LEN)
        ) u_bank (
            .clk      (clk),
            .we_i     (pht_we[b]),
            .waddr_i  (pht_waddr),
            .wdata_i  (pht_wdata),
            .lk_addr_i(lk_addr[b]),
            .lk_data_o(lk_data[b]),
            .up_addr_i(u1_pht_idx),
            .up_data_o(up_data[b])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= INIT;
            clr_cnt_q    <= '0;
            u1_valid_q   <= 1'b0;
            u1_pc_q      <= '0;
            u1_taken_q   <= 1'b0;
            u2_valid_q   <= 1'b0;
            u2_bht_idx_q <= '0;
            u2_bhr_q     <= '0;
            u2_bank_q    <= '0;
            u2_pht_idx_q <= '0;
            u2_ctr_q     <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            u1_valid_q   <= u1_valid_d;
            u1_pc_q      <= u1_pc_d;
            u1_taken_q   <= u1_taken_d;
            u2_valid_q   <= u2_valid_d;
            u2_bht_idx_q <= u2_bht_idx_d;
            u2_bhr_q     <= u2_bhr_d;
            u2_bank_q    <= u2_bank_d;
            u2_pht_idx_q <= u2_pht_idx_d;
            u2_ctr_q     <= u2_ctr_d;
        end
    end

endmodule

// File: tb/tb_local_dir_pred.sv
// Bench for local_dir_pred: directed scenarios then random commits, checked against an
// in-order table model where each commit takes effect two edges after it is accepted.
module tb_local_dir_pred;

    localparam int FETCH_W = 2;
    localparam int BHT_NUM = 32;
    localparam int PHT_N   = 64;
    localparam int CLR_N   = 64;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               clear_i = 1'b0;
    logic               ready_o;
    logic [31:0]        fetch_pc_i = '0;
    logic [FETCH_W-1:0] taken_o;
    logic               upd_valid_i = 1'b0;
    logic [31:0]        upd_pc_i = '0;
    logic               upd_taken_i = 1'b0;

    local_dir_pred #(
        .FETCH_W(2),
        .BHT_NUM(32),
        .BHR_LEN(6),
        .CTR_RST(2'b01)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clear_i    (clear_i),
        .ready_o    (ready_o),
        .fetch_pc_i (fetch_pc_i),
        .taken_o    (taken_o),
        .upd_valid_i(upd_valid_i),
        .upd_pc_i   (upd_pc_i),
        .upd_taken_i(upd_taken_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          t;
        int          due;
    } upd_t;

    int   total = 0;
    int   bad = 0;
    int   m_bht [BHT_NUM];
    int   m_pht [FETCH_W][PHT_N];
    bit   m_ready = 1'b0;
    int   m_cnt = 0;
    int   ecount = 0;
    upd_t pend [$];

    logic [31:0] pool [8] = '{32'h1C000000, 32'h1C000004, 32'h1C000010, 32'h1C000014,
                              32'h1C000210, 32'h1C000404, 32'h1C000018, 32'h1C00021C};

    function automatic int f_bank(input logic [31:0] pc);
        return int'((pc / 4) % FETCH_W);
    endfunction

    function automatic int f_hash(input logic [31:0] pc);
        return int'((pc / 8) % PHT_N);
    endfunction

    function automatic int f_bidx(input logic [31:0] pc);
        return int'((pc / 512) % BHT_NUM);
    endfunction

    function automatic logic [1:0] m_pred(input logic [31:0] fpc);
        logic [1:0]  r;
        logic [31:0] spc;
        r = '0;
        for (int s = 0; s < FETCH_W; s++) begin
            spc  = ((fpc / 4) + s) * 4;
            r[s] = (m_pht[f_bank(spc)][m_bht[f_bidx(spc)] ^ f_hash(spc)] >= 2);
        end
        return m_ready ? r : 2'b00;
    endfunction

    task automatic m_apply(input upd_t u);
        int b, bi, idx;
        b   = f_bank(u.pc);
        bi  = f_bidx(u.pc);
        idx = m_bht[bi] ^ f_hash(u.pc);
        if (u.t) begin
            if (m_pht[b][idx] < 3) m_pht[b][idx]++;
        end else begin
            if (m_pht[b][idx] > 0) m_pht[b][idx]--;
        end
        m_bht[bi] = (m_bht[bi] * 2 + int'(u.t)) % PHT_N;
    endtask

    task automatic m_clear_tables();
        for (int i = 0; i < BHT_NUM; i++) m_bht[i] = 0;
        for (int b = 0; b < FETCH_W; b++)
            for (int i = 0; i < PHT_N; i++) m_pht[b][i] = 1;
    endtask

    task automatic model_edge();
        upd_t u;
        ecount++;
        if (!resetn) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            pend.delete();
        end else if (clear_i) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            pend.delete();
        end else begin
            while (pend.size() > 0 && pend[0].due <= ecount) begin
                u = pend.pop_front();
                m_apply(u);
            end
            if (m_ready && upd_valid_i) begin
                u.pc  = upd_pc_i;
                u.t   = upd_taken_i;
                u.due = ecount + 2;
                pend.push_back(u);
            end
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == CLR_N) begin
                    m_ready = 1'b1;
                    m_clear_tables();
                end
            end
        end
    endtask

    task automatic check(input string tag);
        logic [1:0] exp_t;
        exp_t = m_pred(fetch_pc_i);
        total++;
        assert (ready_o === m_ready)
        else begin
            bad++;
            $error("FAIL %s ready_o got=%b exp=%b", tag, ready_o, m_ready);
        end
        total++;
        assert (taken_o === exp_t)
        else begin
            bad++;
            $error("FAIL %s taken_o pc=%h got=%b exp=%b", tag, fetch_pc_i, taken_o, exp_t);
        end
    endtask

    task automatic cyc(input string tag, input logic [31:0] fpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input bit clr);
        fetch_pc_i  = fpc;
        upd_valid_i = uv;
        upd_pc_i    = upc;
        upd_taken_i = ut;
        clear_i     = clr;
        #2;
        check(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc("reset", pool[i], 1'b1, pool[i], 1'b1, 1'b0);
        resetn = 1'b1;

        // INIT window: commits must be dropped, ready low for 64 edges
        for (int i = 0; i < 70; i++)
            cyc("init", pool[$urandom_range(0, 7)], 1'b1, pool[$urandom_range(0, 7)], 1'b1, 1'b0);

        // training a single branch back-to-back, then continuing until it predicts taken
        cyc("train2", 32'h1C000010, 1'b1, 32'h1C000010, 1'b1, 1'b0);
        cyc("train2", 32'h1C000010, 1'b1, 32'h1C000010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("train2_idle", 32'h1C000010, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc("train8", 32'h1C000010, 1'b1, 32'h1C000010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("train8_idle", 32'h1C000010, 1'b0, '0, 1'b0, 1'b0);

        // floor saturation: repeated not-taken must not wrap to strongly taken
        for (int i = 0; i < 10; i++) cyc("sat_lo", 32'h1C000014, 1'b1, 32'h1C000014, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("sat_lo_idle", 32'h1C000014, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc("sat_hi", 32'h1C000014, 1'b1, 32'h1C000014, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("sat_hi_idle", 32'h1C000014, 1'b0, '0, 1'b0, 1'b0);

        // dual slots: training slot 1 must leave slot 0 alone
        for (int i = 0; i < 8; i++) cyc("dual", 32'h1C000000, 1'b1, 32'h1C000004, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("dual_idle", 32'h1C000000, 1'b0, '0, 1'b0, 1'b0);

        // flush with a same-cycle commit and commits in flight
        cyc("flush_pre", 32'h1C000010, 1'b1, 32'h1C000010, 1'b1, 1'b0);
        cyc("flush", 32'h1C000010, 1'b1, 32'h1C000010, 1'b1, 1'b1);
        for (int i = 0; i < 66; i++) cyc("flush_init", 32'h1C000010, 1'b1, 32'h1C000010, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc("flush_sweep", pool[i], 1'b0, '0, 1'b0, 1'b0);

        // retrain so a prediction is high, then async reset between edges
        for (int i = 0; i < 10; i++) cyc("pre_rst", 32'h1C000010, 1'b1, 32'h1C000010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("pre_rst_idle", 32'h1C000010, 1'b0, '0, 1'b0, 1'b0);
        #3;
        resetn = 1'b0;
        #1;
        total++;
        assert (ready_o === 1'b0)
        else begin
            bad++;
            $error("FAIL async_rst ready_o got=%b exp=0", ready_o);
        end
        total++;
        assert (taken_o === 2'b00)
        else begin
            bad++;
            $error("FAIL async_rst taken_o got=%b exp=00", taken_o);
        end
        @(posedge clk);
        model_edge();
        #1;
        cyc("rst_hold", 32'h1C000010, 1'b1, 32'h1C000010, 1'b1, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 68; i++) cyc("rst_init", 32'h1C000010, 1'b0, '0, 1'b0, 1'b0);

        // random commits over a small PC pool to exercise forwarding hazards
        for (int i = 0; i < 600; i++)
            cyc("random", pool[$urandom_range(0, 7)], ($urandom_range(0, 3) != 0),
                pool[$urandom_range(0, 7)], ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 249) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
